// File: rtl/seg7_entry_scan.sv
// Keypad-entry digit store driving one time-multiplexed 7-segment bus.
// Optional SEG7_LEADING_BLANK_EN blanks positions at or above the entry count.
module seg7_entry_scan #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int OVERWRITE  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        key_code,
  input  logic                              key_valid,
  input  logic                              bksp,
  input  logic                              clr,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             dig_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full,
  output logic                              ovf
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);

  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  logic [3:0]            digit_q [NUM_DIGITS];
  logic [3:0]            digit_d [NUM_DIGITS];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  full_w;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h67;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign full_w = (count_q == CNT_W'(NUM_DIGITS));

  // clr beats bksp beats key_valid; the losers in a shared cycle are dropped
  always_comb begin
    digit_d = digit_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = 4'h0;
      count_d = '0;
    end else if (bksp) begin
      if (count_q != '0) begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) digit_d[i] = digit_q[i+1];
        digit_d[NUM_DIGITS-1] = 4'h0;
        count_d = count_q - CNT_W'(1);
      end
    end else if (key_valid) begin
      if (!full_w || (OVERWRITE != 0)) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) digit_d[i] = digit_q[i-1];
        digit_d[0] = key_code;
      end
      if (!full_w) count_d = count_q + CNT_W'(1);
      else         ovf_d   = 1'b1;
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    seg_raw = hex7(digit_q[idx_q]);
`ifdef SEG7_LEADING_BLANK_EN
    // an empty display still shows a single "0" in the rightmost position
    if (CNT_W'(idx_q) >= count_q)
      seg_raw = ((count_q == '0) && (idx_q == '0)) ? 7'h3F : 7'h00;
`endif
    onehot   = NUM_DIGITS'(1) << idx_q;
    seg_d    = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dig_en_d = (ACTIVE_LOW != 0) ? ~onehot  : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dig_en_q <= DIG_OFF;
    end else begin
      digit_q  <= digit_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;
  assign count  = count_q;
  assign full   = full_w;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seg7_entry_scan.sv
// Scoreboard bench: an overwrite instance and a reject instance share all inputs.
// Expectations follow SEG7_LEADING_BLANK_EN the same way the design does.
module tb_seg7_entry_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid, bksp, clr;
  logic [6:0] seg, seg_nw;
  logic [3:0] dig_en, dig_en_nw;
  logic [2:0] count, count_nw;
  logic       full, full_nw, ovf, ovf_nw;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic [2:0] count;
    logic       full;
    logic       ovf;
  } exp_t;

  exp_t       sb_ow[$];
  exp_t       sb_nw[$];
  logic [3:0] m_dig [2][ND];
  int         m_cnt [2];
  int         cyc;

  always #5 clk = ~clk;

  seg7_entry_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1), .OVERWRITE(1)) u_dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .bksp(bksp),
    .clr(clr), .seg(seg), .dig_en(dig_en), .count(count), .full(full), .ovf(ovf));

  seg7_entry_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1), .OVERWRITE(0)) u_dut_nw (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .bksp(bksp),
    .clr(clr), .seg(seg_nw), .dig_en(dig_en_nw), .count(count_nw), .full(full_nw),
    .ovf(ovf_nw));

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h67;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic [6:0] s,
                     input logic [3:0] d, input logic [2:0] c, input logic f, input logic o);
    chk($sformatf("%s_seg@%0d", who, cyc), 32'(s), 32'(e.seg));
    chk($sformatf("%s_dig_en@%0d", who, cyc), 32'(d), 32'(e.dig_en));
    chk($sformatf("%s_count@%0d", who, cyc), 32'(c), 32'(e.count));
    chk($sformatf("%s_full@%0d", who, cyc), 32'(f), 32'(e.full));
    chk($sformatf("%s_ovf@%0d", who, cyc), 32'(o), 32'(e.ovf));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dig_en"}, 32'(dig_en), 32'hF);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf), 32'h0);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_nw_seg"}, 32'(seg_nw), 32'h7F);
    chk({tag, "_nw_dig_en"}, 32'(dig_en_nw), 32'hF);
    chk({tag, "_nw_count"}, 32'(count_nw), 32'h0);
  endtask

  task automatic reset_model();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < ND; i++) m_dig[n][i] = 4'h0;
      m_cnt[n] = 0;
    end
    cyc = 0;
    sb_ow.delete();
    sb_nw.delete();
  endtask

  // one clock: predict both instances, drive strobes, then score what comes out
  task automatic step(input bit kv, input logic [3:0] code, input bit bk, input bit cl);
    exp_t       e;
    int         idx;
    logic [6:0] raw;
    key_valid = kv; key_code = code; bksp = bk; clr = cl;
    idx = (cyc / SD) % ND;
    for (int n = 0; n < 2; n++) begin
      raw = hex7(m_dig[n][idx]);
`ifdef SEG7_LEADING_BLANK_EN
      if (idx >= m_cnt[n]) raw = (m_cnt[n] == 0 && idx == 0) ? 7'h3F : 7'h00;
`endif
      e.seg    = ~raw;
      e.dig_en = ~(4'b0001 << idx);
      e.ovf    = 1'b0;
      if (cl) begin
        for (int i = 0; i < ND; i++) m_dig[n][i] = 4'h0;
        m_cnt[n] = 0;
      end else if (bk) begin
        if (m_cnt[n] > 0) begin
          for (int i = 0; i < ND - 1; i++) m_dig[n][i] = m_dig[n][i+1];
          m_dig[n][ND-1] = 4'h0;
          m_cnt[n]--;
        end
      end else if (kv) begin
        if (m_cnt[n] == ND) e.ovf = 1'b1;
        if (m_cnt[n] < ND || n == 0) begin
          for (int i = ND - 1; i > 0; i--) m_dig[n][i] = m_dig[n][i-1];
          m_dig[n][0] = code;
        end
        if (m_cnt[n] < ND) m_cnt[n]++;
      end
      e.count = 3'(m_cnt[n]);
      e.full  = (m_cnt[n] == ND);
      if (n == 0) sb_ow.push_back(e);
      else        sb_nw.push_back(e);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0; bksp = 1'b0; clr = 1'b0;
    if (sb_ow.size() == 0) chk("sb_ow_empty", 32'd1, 32'd0);
    else cmp("ow", sb_ow.pop_front(), seg, dig_en, count, full, ovf);
    if (sb_nw.size() == 0) chk("sb_nw_empty", 32'd1, 32'd0);
    else cmp("nw", sb_nw.pop_front(), seg_nw, dig_en_nw, count_nw, full_nw, ovf_nw);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b1, code, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; key_code = 4'h0; key_valid = 1'b0; bksp = 1'b0; clr = 1'b0;
    reset_model();
    #12;
    chk_reset("rst_hold");
    rst = 1'b0;
    #1;
    chk_reset("rst_rel");

    idle(20);
    key(4'h1); key(4'h2); key(4'h3);
    idle(16);
    key(4'h4); key(4'h5);
    idle(16);

    step(1'b0, 4'h0, 1'b0, 1'b1);
    key(4'h1); key(4'h2); key(4'h3);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(8);

    key(4'h7); key(4'h8);
    step(1'b1, 4'h9, 1'b1, 1'b1);
    idle(4);
    key(4'h8); key(4'h9);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    key(4'hA);
    idle(16);
    key(4'hB); key(4'hC);
    #3 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(posedge clk);
    #1 chk_reset("rst_edge");
    rst = 1'b0;
    reset_model();
    chk_reset("rst_rel2");
    idle(8);

    key(4'hD); key(4'hE); key(4'hF); key(4'h6);
    key(4'h0); key(4'h9);
    idle(16);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    key(4'h5);
    idle(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
